tap_loader: RTL and testbench
=============================

# tap_loader

Parametrised cached-tape loader: walks a byte-addressed TAP image in the tape cache BRAM, parses each Oric tape header, and writes the program body of a selected file into main memory. It generalises the single-file cached loader with:
- multi-file tapes and file selection by index;
- an end-address-bounded copy;
- configurable widths and sync length;
- explicit error reporting.

It sits between the tape cache BRAM and the RAM write port of the Oric core.

## Interface
Parameters:
- CACHE_AW, 16: cache address width; maximum image size is 2^CACHE_AW bytes.
- MEM_AW, 16: memory address width; header addresses are zero-extended to this width.
- SYNC_MIN, 3: minimum number of consecutive 0x16 bytes required before 0x24.
- NAME_MAX, 16: maximum filename length, excluding the 0x00 terminator.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- tape_size  in  CACHE_AW+1  number of valid image bytes; sampled on start.
- file_sel  in  8  zero-based index of the file to load; sampled on start.
- cache_addr  out  CACHE_AW  BRAM read address.
- cache_dout  in  8  BRAM data; valid one cycle after cache_addr.
- mem_addr  out  MEM_AW  RAM write address.
- mem_dout  out  8  RAM write data.
- mem_wr  out  1  one-cycle write strobe per byte.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on failure.
- err_code  out  2  failure cause: 1 = end of image, 2 = range, 3 = name; held until the next start.
- loadpoint  out  MEM_AW  start address of the loaded file.
- end_addr  out  MEM_AW  end address of the loaded file.
- file_type  out  8  header type byte.
- tape_autorun  out  1  one-cycle pulse coincident with done when the autorun byte is nonzero.

## Operation
Byte stream fetch:
- The reader issues sequential cache addresses starting at 0.
- It presents one byte per cycle with a valid flag.
- Reading byte index tape_size or beyond means end of image.

States: IDLE, SYNC, HDR, NAME, COPY, SKIP, FIN.

- IDLE: on start, latch tape_size and file_sel, clear the file counter and err_code, go to SYNC.
- SYNC: keep a run count of 0x16 bytes.
  - 0x16: increment the count, saturating at SYNC_MIN.
  - 0x24 with count ≥ SYNC_MIN: go to HDR.
  - Any other byte, including 0x24 with too short a run: clear the count.
- HDR: consume exactly 9 bytes in this order: reserved, reserved, type, autorun, end hi, end lo, start hi, start lo, reserved. Then go to NAME.
- NAME: consume bytes until 0x00.
  - Name bytes are ignored.
  - If NAME_MAX+1 bytes arrive with no 0x00, fail with err 3.
  - On the 0x00 byte:
    - If start > end, fail with err 2.
    - Otherwise compute len = end − start + 1 at MEM_AW+1 bits.
    - If the file counter equals file_sel, go to COPY; otherwise go to SKIP.
- COPY: for each of len bytes:
  - Assert mem_wr with mem_addr = start + k and mem_dout = the byte.
  - After the last byte go to FIN.
- SKIP: discard len bytes, increment the file counter, return to SYNC with the run count cleared.
- FIN: in one cycle:
  - pulse done;
  - pulse tape_autorun if the autorun byte ≠ 0x00;
  - update loadpoint, end_addr and file_type;
  - go to IDLE.
- End of image in any state other than IDLE or FIN, including when file_sel is not found: pulse error with err 1 and go to IDLE. The partial copy is not undone.

## Timing
- Reset values: mem_wr, busy, done, error and tape_autorun are 0; all addresses and registers are 0; the state is IDLE.
- Reset mid-load: mem_wr is 0 in the cycle after reset is asserted; no done or error pulse is issued.
- busy rises the cycle after start and falls in the cycle of the done or error pulse.
- Cache fetch latency is 1 cycle; after that the block processes one byte per cycle with no bubbles.
- Write rate: the first mem_wr occurs 2 cycles after the terminating 0x00 of the name is presented. Writes are then back-to-back, exactly len strobes.
- done follows 1 cycle after the last mem_wr.
- mem_addr never wraps: end = 0xFFFF (at MEM_AW 16) writes up to and including 0xFFFF.
- A start pulse coincident with done or error is ignored.

## Structure
- Shared package tap_pkg holds:
  - state enum;
  - err_code constants;
  - SYNC_BYTE 0x16 and HDR_MARK 0x24;
  - HDR_LEN 9.
- One sub-module, tap_byte_reader:
  - BRAM address counter;
  - 1-cycle valid pipeline;
  - end-of-image compare against the latched tape_size;
  - advance/restart controls.
- The top-level module contains the parser FSM, the length and address counters, and the file counter.

## Test plan
- Single-file image "16 16 16 16 24 FF FF 00 00 05 1F 05 01 03 'TESTSAVE' 00" followed by 31 bytes, file_sel=0:
  - 31 writes to 0x0501–0x051F;
  - done one cycle after the write to 0x051F;
  - loadpoint=0x0501, no tape_autorun.
- Two files, the second at 0x0600–0x0603 with autorun C7, file_sel=1:
  - the first file is skipped with no mem_wr;
  - exactly 4 writes to 0x0600–0x0603;
  - tape_autorun pulses with done.
- Only 2 sync bytes before 0x24, then a valid header later in the image: the first 0x24 is ignored and the later file loads.
- tape_size truncates the image 5 bytes into the body: 5 writes, then error with err_code=1, with no done pulse.
- Header with start 0x0600 and end 0x05FF: error with err_code=2 and no writes. An unterminated 17-byte name: err_code=3.
- Reset asserted during COPY: mem_wr is 0 the next cycle; a new start then performs a full reload correctly.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types and constants for the cached TAP loader.
package tap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR,
    ST_NAME,
    ST_COPY,
    ST_SKIP,
    ST_FIN
  } tap_state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_EOF   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_NAME  = 2'd3;

  localparam logic [7:0] SYNC_BYTE = 8'h16;
  localparam logic [7:0] HDR_MARK  = 8'h24;

  localparam int unsigned HDR_LEN = 9;
  localparam int unsigned HDR_IW  = 4;

  // Fields captured from the 9-byte Oric tape header.
  typedef struct packed {
    logic [7:0]  ftype;
    logic [7:0]  autorun;
    logic [15:0] end_a;
    logic [15:0] start_a;
  } tap_hdr_t;

endpackage

// File: rtl/tap_loader_if.sv
// Cache read port and RAM write port seen by the loader.
interface tap_loader_if #(
  parameter int unsigned CACHE_AW = 16,
  parameter int unsigned MEM_AW   = 16
) ();

  logic [CACHE_AW-1:0] cache_addr;
  logic [7:0]          cache_dout;
  logic [MEM_AW-1:0]   mem_addr;
  logic [7:0]          mem_dout;
  logic                mem_wr;

  modport master (
    output cache_addr,
    input  cache_dout,
    output mem_addr,
    output mem_dout,
    output mem_wr
  );

  modport slave (
    input  cache_addr,
    output cache_dout,
    input  mem_addr,
    input  mem_dout,
    input  mem_wr
  );

endinterface

// File: rtl/tap_byte_reader.sv
// Sequential byte fetcher over the tape cache BRAM with end-of-image detection.
module tap_byte_reader #(
  parameter int unsigned CACHE_AW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  input  logic                run,
  input  logic [CACHE_AW:0]   size_in,
  output logic [CACHE_AW-1:0] cache_addr,
  input  logic [7:0]          cache_dout,
  output logic                byte_valid_c,
  output logic                byte_eof_c,
  output logic [7:0]          byte_data_c
);

  localparam int unsigned AW1 = CACHE_AW + 1;

  logic [CACHE_AW:0] rd_addr;
  logic [CACHE_AW:0] size_q;
  logic              pend;
  logic              pend_eof;

  // Address counter and one-cycle valid pipeline matching the BRAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr  <= '0;
      size_q   <= '0;
      pend     <= 1'b0;
      pend_eof <= 1'b0;
    end else if (restart) begin
      rd_addr  <= '0;
      size_q   <= size_in;
      pend     <= 1'b0;
      pend_eof <= 1'b0;
    end else if (run) begin
      pend     <= 1'b1;
      pend_eof <= (rd_addr >= size_q);
      // Park at tape_size so the counter cannot wrap back into valid data.
      if (rd_addr < size_q) begin
        rd_addr <= rd_addr + AW1'(1);
      end
    end else begin
      pend     <= 1'b0;
      pend_eof <= 1'b0;
    end
  end

  assign cache_addr   = rd_addr[CACHE_AW-1:0];
  assign byte_valid_c = pend & ~pend_eof;
  assign byte_eof_c   = pend & pend_eof;
  assign byte_data_c  = cache_dout;

endmodule

// File: rtl/tap_loader.sv
// Multi-file cached TAP loader: parses Oric headers and copies the selected body into RAM.
module tap_loader
  import tap_pkg::*;
#(
  parameter int unsigned CACHE_AW = 16,
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned SYNC_MIN = 3,
  parameter int unsigned NAME_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CACHE_AW:0]   tape_size,
  input  logic [7:0]          file_sel,
  tap_loader_if.master        bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [MEM_AW-1:0]   loadpoint,
  output logic [MEM_AW-1:0]   end_addr,
  output logic [7:0]          file_type,
  output logic                tape_autorun
);

  localparam int unsigned LEN_W   = MEM_AW + 1;
  localparam int unsigned SC_W    = $clog2(SYNC_MIN + 2);
  localparam int unsigned NAME_CW = $clog2(NAME_MAX + 2);

  tap_state_e          state, state_d;
  logic [SC_W-1:0]     sync_cnt, sync_cnt_d;
  logic [HDR_IW-1:0]   hdr_idx, hdr_idx_d;
  logic [NAME_CW-1:0]  name_cnt, name_cnt_d;
  tap_hdr_t            hdr, hdr_d;
  logic [LEN_W-1:0]    len_cnt, len_d;
  logic [MEM_AW-1:0]   wr_addr, wr_addr_d;
  logic [7:0]          file_cnt, file_cnt_d;
  logic [7:0]          sel_q, sel_d;

  logic                mem_wr_q, mem_wr_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                busy_d, done_d, error_d, tape_autorun_d;
  logic [1:0]          err_code_d;
  logic [MEM_AW-1:0]   loadpoint_d, end_addr_d;
  logic [7:0]          file_type_d;

  logic                restart_c;
  logic                run_c;
  logic                byte_valid_c;
  logic                byte_eof_c;
  logic [7:0]          byte_data_c;
  logic [MEM_AW-1:0]   start_m_c;
  logic [MEM_AW-1:0]   end_m_c;

  // Byte stream from the tape cache.
  tap_byte_reader #(
    .CACHE_AW (CACHE_AW)
  ) u_reader (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart_c),
    .run          (run_c),
    .size_in      (tape_size),
    .cache_addr   (bus.cache_addr),
    .cache_dout   (bus.cache_dout),
    .byte_valid_c (byte_valid_c),
    .byte_eof_c   (byte_eof_c),
    .byte_data_c  (byte_data_c)
  );

  assign run_c     = (state == ST_SYNC) || (state == ST_HDR) || (state == ST_NAME) ||
                     (state == ST_COPY) || (state == ST_SKIP);
  assign start_m_c = MEM_AW'(hdr.start_a);
  assign end_m_c   = MEM_AW'(hdr.end_a);

  // Parser next-state, counters and registered output values.
  always_comb begin
    state_d        = state;
    sync_cnt_d     = sync_cnt;
    hdr_idx_d      = hdr_idx;
    name_cnt_d     = name_cnt;
    hdr_d          = hdr;
    len_d          = len_cnt;
    wr_addr_d      = wr_addr;
    file_cnt_d     = file_cnt;
    sel_d          = sel_q;
    mem_wr_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_dout_d     = mem_dout_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    tape_autorun_d = 1'b0;
    err_code_d     = err_code;
    loadpoint_d    = loadpoint;
    end_addr_d     = end_addr;
    file_type_d    = file_type;
    restart_c      = 1'b0;

    case (state)
      ST_IDLE: begin
        // A start landing on the done/error pulse is dropped.
        if (start && !done && !error) begin
          state_d    = ST_SYNC;
          sel_d      = file_sel;
          file_cnt_d = '0;
          sync_cnt_d = '0;
          err_code_d = ERR_NONE;
          restart_c  = 1'b1;
        end
      end

      ST_FIN: begin
        done_d         = 1'b1;
        tape_autorun_d = (hdr.autorun != 8'h00);
        loadpoint_d    = start_m_c;
        end_addr_d     = end_m_c;
        file_type_d    = hdr.ftype;
        state_d        = ST_IDLE;
      end

      default: begin
        if (byte_eof_c) begin
          error_d    = 1'b1;
          err_code_d = ERR_EOF;
          state_d    = ST_IDLE;
        end else if (byte_valid_c) begin
          case (state)
            ST_SYNC: begin
              if ((byte_data_c == HDR_MARK) && (sync_cnt == SC_W'(SYNC_MIN))) begin
                state_d   = ST_HDR;
                hdr_idx_d = '0;
              end else if (byte_data_c == SYNC_BYTE) begin
                if (sync_cnt != SC_W'(SYNC_MIN)) begin
                  sync_cnt_d = sync_cnt + SC_W'(1);
                end
              end else begin
                sync_cnt_d = '0;
              end
            end

            ST_HDR: begin
              case (hdr_idx)
                HDR_IW'(2): hdr_d.ftype          = byte_data_c;
                HDR_IW'(3): hdr_d.autorun        = byte_data_c;
                HDR_IW'(4): hdr_d.end_a[15:8]    = byte_data_c;
                HDR_IW'(5): hdr_d.end_a[7:0]     = byte_data_c;
                HDR_IW'(6): hdr_d.start_a[15:8]  = byte_data_c;
                HDR_IW'(7): hdr_d.start_a[7:0]   = byte_data_c;
                default: ;
              endcase
              hdr_idx_d = hdr_idx + HDR_IW'(1);
              if (hdr_idx == HDR_IW'(HDR_LEN - 1)) begin
                state_d    = ST_NAME;
                name_cnt_d = '0;
              end
            end

            ST_NAME: begin
              if (byte_data_c == 8'h00) begin
                if (hdr.start_a > hdr.end_a) begin
                  error_d    = 1'b1;
                  err_code_d = ERR_RANGE;
                  state_d    = ST_IDLE;
                end else begin
                  len_d     = LEN_W'(end_m_c) - LEN_W'(start_m_c) + LEN_W'(1);
                  wr_addr_d = start_m_c;
                  state_d   = (file_cnt == sel_q) ? ST_COPY : ST_SKIP;
                end
              end else if (name_cnt == NAME_CW'(NAME_MAX)) begin
                error_d    = 1'b1;
                err_code_d = ERR_NAME;
                state_d    = ST_IDLE;
              end else begin
                name_cnt_d = name_cnt + NAME_CW'(1);
              end
            end

            ST_COPY: begin
              mem_wr_d   = 1'b1;
              mem_addr_d = wr_addr;
              mem_dout_d = byte_data_c;
              wr_addr_d  = wr_addr + MEM_AW'(1);
              len_d      = len_cnt - LEN_W'(1);
              if (len_cnt == LEN_W'(1)) begin
                state_d = ST_FIN;
              end
            end

            ST_SKIP: begin
              len_d = len_cnt - LEN_W'(1);
              if (len_cnt == LEN_W'(1)) begin
                file_cnt_d = file_cnt + 8'd1;
                sync_cnt_d = '0;
                state_d    = ST_SYNC;
              end
            end

            default: ;
          endcase
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sync_cnt     <= '0;
      hdr_idx      <= '0;
      name_cnt     <= '0;
      hdr          <= '0;
      len_cnt      <= '0;
      wr_addr      <= '0;
      file_cnt     <= '0;
      sel_q        <= '0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      loadpoint    <= '0;
      end_addr     <= '0;
      file_type    <= '0;
      tape_autorun <= 1'b0;
    end else begin
      state        <= state_d;
      sync_cnt     <= sync_cnt_d;
      hdr_idx      <= hdr_idx_d;
      name_cnt     <= name_cnt_d;
      hdr          <= hdr_d;
      len_cnt      <= len_d;
      wr_addr      <= wr_addr_d;
      file_cnt     <= file_cnt_d;
      sel_q        <= sel_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      err_code     <= err_code_d;
      loadpoint    <= loadpoint_d;
      end_addr     <= end_addr_d;
      file_type    <= file_type_d;
      tape_autorun <= tape_autorun_d;
    end
  end

  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dout = mem_dout_q;

endmodule

// File: tb/tb_tap_loader.sv
// Directed bench for tap_loader: builds TAP images in a BRAM model and checks RAM writes and status.
module tb_tap_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [16:0] tape_size = '0;
  logic [7:0]  file_sel = '0;
  logic        busy, done, error, tape_autorun;
  logic [1:0]  err_code;
  logic [15:0] loadpoint, end_addr;
  logic [7:0]  file_type;

  tap_loader_if #(.CACHE_AW(16), .MEM_AW(16)) bus ();

  tap_loader #(
    .CACHE_AW (16),
    .MEM_AW   (16),
    .SYNC_MIN (3),
    .NAME_MAX (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tape_size    (tape_size),
    .file_sel     (file_sel),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .loadpoint    (loadpoint),
    .end_addr     (end_addr),
    .file_type    (file_type),
    .tape_autorun (tape_autorun)
  );

  always #5 clk = ~clk;

  logic [7:0] cache_mem [0:4095];
  int img_len;
  int body_idx;

  // BRAM model: one-cycle read latency.
  always @(posedge clk) bus.cache_dout <= cache_mem[bus.cache_addr[11:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  int          wq_cyc  [$];
  int done_n, err_n, ar_n, ar_with_done, done_cyc;
  int errors = 0;
  int checks = 0;

  // Observer of RAM writes and status pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_wr) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_dout);
      wq_cyc.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      if (tape_autorun) ar_with_done++;
    end
    if (tape_autorun) ar_n++;
    if (error) err_n++;
  end

  function automatic logic [7:0] bodyb(input int j, input logic [7:0] seed);
    return 8'(j * 13) + seed;
  endfunction

  task automatic clear_image();
    for (int i = 0; i < 4096; i++) cache_mem[i] = 8'h55;
    img_len = 0;
  endtask

  task automatic put(input logic [7:0] b);
    cache_mem[img_len] = b;
    img_len++;
  endtask

  task automatic put_file(input int nsync, input logic [7:0] ftype, input logic [7:0] autorun,
                          input logic [15:0] s, input logic [15:0] e, input int name_len,
                          input int body_len, input logic [7:0] seed);
    for (int i = 0; i < nsync; i++) put(8'h16);
    put(8'h24); put(8'hFF); put(8'hFF); put(ftype); put(autorun);
    put(e[15:8]); put(e[7:0]); put(s[15:8]); put(s[7:0]); put(8'h03);
    for (int i = 0; i < name_len; i++) put(8'h41 + 8'(i % 26));
    put(8'h00);
    body_idx = img_len;
    for (int j = 0; j < body_len; j++) put(bodyb(j, seed));
  endtask

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    done_n = 0; err_n = 0; ar_n = 0; ar_with_done = 0; done_cyc = -1;
  endtask

  task automatic run_load(input logic [7:0] sel, input int size, output int p, output bit to);
    clear_mon();
    @(negedge clk);
    tape_size = 17'(size);
    file_sel  = sel;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p  = cyc;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done || error) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", bus.mem_wr); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
    checks++; if (loadpoint !== 16'h0) begin errors++; $display("FAIL reset_loadpoint: got %h expected 0000", loadpoint); end
    checks++; if (bus.cache_addr !== 16'h0) begin errors++; $display("FAIL reset_cache_addr: got %h expected 0000", bus.cache_addr); end
    checks++; if (tape_autorun !== 1'b0) begin errors++; $display("FAIL reset_autorun: got %b expected 0", tape_autorun); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int p; bit to;
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0501, 16'h051F, 8, 31, 8'h10);
    run_load(8'd0, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: got timeout expected done"); end
    checks++; if (wq_addr.size() != 31) begin errors++; $display("FAIL single_count: got %0d expected 31", wq_addr.size()); end
    for (int k = 0; k < wq_addr.size() && k < 31; k++) begin
      checks++;
      if (wq_addr[k] !== 16'(16'h0501 + k) || wq_data[k] !== bodyb(k, 8'h10)) begin
        errors++;
        $display("FAIL single_write[%0d]: got %h/%h expected %h/%h", k, wq_addr[k], wq_data[k],
                 16'(16'h0501 + k), bodyb(k, 8'h10));
      end
    end
    if (wq_cyc.size() > 0) begin
      checks++; if (wq_cyc[0] != p + 2 + body_idx) begin errors++; $display("FAIL single_first_wr_cycle: got %0d expected %0d", wq_cyc[0], p + 2 + body_idx); end
      checks++; if (done_cyc != wq_cyc[wq_cyc.size()-1] + 1) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", done_cyc, wq_cyc[wq_cyc.size()-1] + 1); end
      checks++; if (wq_cyc[wq_cyc.size()-1] != wq_cyc[0] + 30) begin errors++; $display("FAIL single_back_to_back: got %0d expected %0d", wq_cyc[wq_cyc.size()-1], wq_cyc[0] + 30); end
    end
    checks++; if (done_n != 1) begin errors++; $display("FAIL single_done_n: got %0d expected 1", done_n); end
    checks++; if (loadpoint !== 16'h0501) begin errors++; $display("FAIL single_loadpoint: got %h expected 0501", loadpoint); end
    checks++; if (end_addr !== 16'h051F) begin errors++; $display("FAIL single_end_addr: got %h expected 051F", end_addr); end
    checks++; if (ar_n != 0) begin errors++; $display("FAIL single_autorun: got %0d expected 0", ar_n); end
    checks++; if (err_n != 0) begin errors++; $display("FAIL single_error: got %0d expected 0", err_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_multi_file();
    int p; bit to;
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0400, 16'h0407, 4, 8, 8'h20);
    put_file(5, 8'h80, 8'hC7, 16'h0600, 16'h0603, 3, 4, 8'h30);
    run_load(8'd1, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL multi_timeout: got timeout expected done"); end
    checks++; if (wq_addr.size() != 4) begin errors++; $display("FAIL multi_count: got %0d expected 4", wq_addr.size()); end
    for (int k = 0; k < wq_addr.size() && k < 4; k++) begin
      checks++;
      if (wq_addr[k] !== 16'(16'h0600 + k) || wq_data[k] !== bodyb(k, 8'h30)) begin
        errors++;
        $display("FAIL multi_write[%0d]: got %h/%h expected %h/%h", k, wq_addr[k], wq_data[k],
                 16'(16'h0600 + k), bodyb(k, 8'h30));
      end
    end
    checks++; if (ar_with_done != 1 || ar_n != 1) begin errors++; $display("FAIL multi_autorun: got %0d/%0d expected 1/1", ar_with_done, ar_n); end
    checks++; if (file_type !== 8'h80) begin errors++; $display("FAIL multi_file_type: got %h expected 80", file_type); end
    checks++; if (loadpoint !== 16'h0600 || end_addr !== 16'h0603) begin errors++; $display("FAIL multi_addrs: got %h-%h expected 0600-0603", loadpoint, end_addr); end
  endtask

  task automatic test_short_sync();
    int p; bit to;
    clear_image();
    put(8'h16); put(8'h16); put(8'h24); put(8'h07);
    put_file(3, 8'h00, 8'h00, 16'h0700, 16'h0702, 16, 3, 8'h40);
    run_load(8'd0, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to || done_n != 1) begin errors++; $display("FAIL short_sync_done: got %0d expected 1", done_n); end
    checks++; if (wq_addr.size() != 3) begin errors++; $display("FAIL short_sync_count: got %0d expected 3", wq_addr.size()); end
    if (wq_addr.size() == 3) begin
      checks++; if (wq_addr[0] !== 16'h0700 || wq_data[2] !== bodyb(2, 8'h40)) begin errors++; $display("FAIL short_sync_data: got %h/%h expected 0700/%h", wq_addr[0], wq_data[2], bodyb(2, 8'h40)); end
    end
  endtask

  task automatic test_truncate();
    int p; bit to;
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0501, 16'h051F, 8, 31, 8'h10);
    run_load(8'd0, body_idx + 5, p, to);
    repeat (4) @(negedge clk);
    checks++; if (to || err_n != 1) begin errors++; $display("FAIL trunc_error: got %0d expected 1", err_n); end
    checks++; if (wq_addr.size() != 5) begin errors++; $display("FAIL trunc_count: got %0d expected 5", wq_addr.size()); end
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL trunc_err_code: got %0d expected 1", err_code); end
    checks++; if (done_n != 0) begin errors++; $display("FAIL trunc_done: got %0d expected 0", done_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trunc_busy: got %b expected 0", busy); end
  endtask

  task automatic test_range_and_name();
    int p; bit to;
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0600, 16'h05FF, 4, 4, 8'h00);
    run_load(8'd0, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to || err_code !== 2'd2) begin errors++; $display("FAIL range_err_code: got %0d expected 2", err_code); end
    checks++; if (wq_addr.size() != 0 || done_n != 0) begin errors++; $display("FAIL range_writes: got %0d/%0d expected 0/0", wq_addr.size(), done_n); end
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0500, 16'h0501, 17, 2, 8'h00);
    run_load(8'd0, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to || err_code !== 2'd3) begin errors++; $display("FAIL name_err_code: got %0d expected 3", err_code); end
    checks++; if (err_n != 1 || wq_addr.size() != 0) begin errors++; $display("FAIL name_pulses: got %0d/%0d expected 1/0", err_n, wq_addr.size()); end
  endtask

  task automatic test_not_found();
    int p; bit to;
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0500, 16'h0503, 4, 4, 8'h00);
    run_load(8'd2, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to || err_code !== 2'd1) begin errors++; $display("FAIL notfound_err_code: got %0d expected 1", err_code); end
    checks++; if (wq_addr.size() != 0) begin errors++; $display("FAIL notfound_writes: got %0d expected 0", wq_addr.size()); end
  endtask

  task automatic test_top_of_mem();
    int p; bit to;
    clear_image();
    put_file(4, 8'h11, 8'h00, 16'hFFFC, 16'hFFFF, 2, 4, 8'h50);
    run_load(8'd0, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to || done_n != 1) begin errors++; $display("FAIL top_done: got %0d expected 1", done_n); end
    checks++; if (wq_addr.size() != 4) begin errors++; $display("FAIL top_count: got %0d expected 4", wq_addr.size()); end
    if (wq_addr.size() == 4) begin
      checks++; if (wq_addr[3] !== 16'hFFFF) begin errors++; $display("FAIL top_last_addr: got %h expected FFFF", wq_addr[3]); end
    end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL top_err_code_cleared: got %0d expected 0", err_code); end
  endtask

  task automatic test_back_to_back();
    int p; bit to;
    clear_image();
    put_file(3, 8'h00, 8'h00, 16'h0900, 16'h0901, 1, 2, 8'h60);
    run_load(8'd0, img_len, p, to);
    checks++; if (to || done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_ignored: got busy=%b expected 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_still_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_copy();
    int p; bit to;
    clear_image();
    put_file(4, 8'h00, 8'h00, 16'h0800, 16'h0827, 4, 40, 8'h70);
    clear_mon();
    @(negedge clk);
    tape_size = 17'(img_len);
    file_sel  = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (wq_addr.size() >= 5) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++; if (to) begin errors++; $display("FAIL rst_mid_reach_copy: got %0d writes expected >=5", wq_addr.size()); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_wr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_wr: got %b/%b expected 0/0", bus.mem_wr, busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done_n != 0 || err_n != 0) begin errors++; $display("FAIL rst_mid_pulses: got %0d/%0d expected 0/0", done_n, err_n); end
    run_load(8'd0, img_len, p, to);
    repeat (2) @(negedge clk);
    checks++; if (to || done_n != 1) begin errors++; $display("FAIL rst_reload_done: got %0d expected 1", done_n); end
    checks++; if (wq_addr.size() != 40) begin errors++; $display("FAIL rst_reload_count: got %0d expected 40", wq_addr.size()); end
    if (wq_addr.size() == 40) begin
      checks++; if (wq_addr[0] !== 16'h0800 || wq_addr[39] !== 16'h0827 || wq_data[39] !== bodyb(39, 8'h70)) begin
        errors++;
        $display("FAIL rst_reload_span: got %h..%h/%h expected 0800..0827/%h", wq_addr[0], wq_addr[39], wq_data[39], bodyb(39, 8'h70));
      end
    end
  endtask

  initial begin
    clear_mon();
    clear_image();
    test_reset();
    test_single();
    test_multi_file();
    test_short_sync();
    test_truncate();
    test_range_and_name();
    test_not_found();
    test_top_of_mem();
    test_back_to_back();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
